// File: rtl/uart_cmd_line.sv
// uart_cmd_line: line-oriented command parser sitting between the UART
// receive byte stream and the clock/control core.
//
// Collects one line of up to MAX_LEN bytes, decodes it on '\n' into a
// one-cycle command strobe or a range-checked BCD time-set word, and returns
// "OK\n" or "ERROR!\n" on a ready/valid byte stream.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   rx_vld, rx_data       received byte strobe / byte
//   err_req               external error pulse, answered with "ERROR!\n"
//   tx_valid/ready/data   response byte stream (held stable until accepted)
//   cmd_*                 one-cycle command strobes
//   set_vld, set_digits   one-cycle set strobe / held BCD word (field 0 in MSBs)
//   busy                  high whenever not collecting a line
//   drop_cnt              saturating count of bytes discarded while processing
module uart_cmd_line #(
    parameter int MAX_LEN  = 16,
    parameter int N_FIELDS = 3,
    parameter int HOUR_MAX = 23
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_vld,
    input  logic [7:0]            rx_data,
    input  logic                  err_req,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [7:0]            tx_data,
    output logic                  cmd_start,
    output logic                  cmd_reset,
    output logic                  cmd_check,
    output logic                  cmd_setcl,
    output logic                  cmd_exit,
    output logic                  cmd_shutdown,
    output logic                  set_vld,
    output logic [8*N_FIELDS-1:0] set_digits,
    output logic                  busy,
    output logic [7:0]            drop_cnt
);
    localparam int LW      = $clog2(MAX_LEN + 1);
    localparam int SET_LEN = 2 + 2 * N_FIELDS;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_NL = 8'h0A;

    typedef enum logic [2:0] {COLLECT, DROP, DECODE, EXEC, RESP} state_t;
    state_t state, state_nxt;

    logic [MAX_LEN-1:0][7:0] line_buf;
    logic [LW-1:0]           len;
    logic                    ovf;
    logic                    err_pend;
    logic                    resp_err;
    logic [2:0]              resp_idx;
    logic [6:0]              strb;      // {set, shutdown, exit, setcl, check, reset, start}
    logic [6:0]              dec_strb;
    logic [8*N_FIELDS-1:0]   set_word;
    logic                    set_ok;
    logic [7:0]              tens, units;
    logic                    tx_last;
    logic                    err_svc;

    // Exact-length keyword compare; kw is right-aligned ASCII of length kl.
    function automatic logic kw_hit(input logic [MAX_LEN-1:0][7:0] b,
                                    input logic [LW-1:0] n,
                                    input logic [63:0] kw, input int kl);
        logic [63:0] kwl;
        logic        hit;
        kwl = kw << (8 * (8 - kl));
        hit = (int'(n) == kl);
        for (int i = 0; i < 8; i++)
            if (i < kl && b[i] != kwl[8*(7-i) +: 8]) hit = 1'b0;
        return hit;
    endfunction

    // Positions past the buffer read as 0 so a set format longer than the
    // buffer simply never matches.
    function automatic logic [7:0] byte_at(input logic [MAX_LEN-1:0][7:0] b, input int i);
        return (i < MAX_LEN) ? b[i % MAX_LEN] : 8'h00;
    endfunction

    function automatic logic is_digit(input logic [7:0] c);
        return c >= 8'h30 && c <= 8'h39;
    endfunction

    function automatic logic [7:0] resp_byte(input logic err, input logic [2:0] idx);
        if (!err) begin
            case (idx)
                3'd0:    return 8'h4F;   // O
                3'd1:    return 8'h4B;   // K
                default: return 8'h0A;
            endcase
        end
        case (idx)
            3'd0:    return 8'h45;       // E
            3'd1:    return 8'h52;       // R
            3'd2:    return 8'h52;       // R
            3'd3:    return 8'h4F;       // O
            3'd4:    return 8'h52;       // R
            3'd5:    return 8'h21;       // !
            default: return 8'h0A;
        endcase
    endfunction

    // Line decode, evaluated against the registered buffer during DECODE.
    always_comb begin
        tens     = 8'h00;
        units    = 8'h00;
        set_word = '0;
        set_ok   = (int'(len) == SET_LEN) && line_buf[0] == 8'h73 && line_buf[1] == 8'h20;
        for (int f = 0; f < N_FIELDS; f++) begin
            tens  = byte_at(line_buf, 2 + 2 * f);
            units = byte_at(line_buf, 3 + 2 * f);
            if (!is_digit(tens) || !is_digit(units))
                set_ok = 1'b0;
            else if (int'(tens[3:0]) * 10 + int'(units[3:0]) > (f == 0 ? HOUR_MAX : 59))
                set_ok = 1'b0;
            set_word[8*(N_FIELDS-1-f) +: 8] = {tens[3:0], units[3:0]};
        end
        dec_strb = {set_ok,
                    kw_hit(line_buf, len, 64'("shutdown"), 8),
                    kw_hit(line_buf, len, 64'("exit"), 4),
                    kw_hit(line_buf, len, 64'("setcl"), 5),
                    kw_hit(line_buf, len, 64'("check"), 5),
                    kw_hit(line_buf, len, 64'("reset"), 5),
                    kw_hit(line_buf, len, 64'("start"), 5)};
        // Overflowed lines are rejected even if the stored prefix matches.
        if (ovf || len == '0) dec_strb = '0;
    end

    assign tx_last = resp_idx == (resp_err ? 3'd6 : 3'd2);
    // A byte arriving in the same cycle takes priority over the pending error.
    assign err_svc = (state == COLLECT) && err_pend && !rx_vld;

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: begin
                if (rx_vld) begin
                    if (rx_data == CH_NL)
                        state_nxt = DECODE;
                    else if (rx_data != CH_CR && int'(len) == MAX_LEN)
                        state_nxt = DROP;
                end else if (err_pend) begin
                    state_nxt = EXEC;
                end
            end
            DROP:    if (rx_vld && rx_data == CH_NL) state_nxt = DECODE;
            DECODE:  state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (tx_ready && tx_last) state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= COLLECT;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_buf   <= '0;
            len        <= '0;
            ovf        <= 1'b0;
            err_pend   <= 1'b0;
            resp_err   <= 1'b0;
            resp_idx   <= '0;
            strb       <= '0;
            set_digits <= '0;
            drop_cnt   <= '0;
        end else begin
            strb <= '0;
            case (state)
                COLLECT: begin
                    if (rx_vld) begin
                        if (rx_data != CH_CR && rx_data != CH_NL) begin
                            if (int'(len) == MAX_LEN) begin
                                ovf <= 1'b1;
                            end else begin
                                line_buf[len] <= rx_data;
                                len           <= len + 1'b1;
                            end
                        end
                    end else if (err_pend) begin
                        len      <= '0;
                        ovf      <= 1'b0;
                        resp_err <= 1'b1;
                    end
                end
                DECODE: begin
                    strb     <= dec_strb;
                    resp_err <= ~|dec_strb;
                    if (dec_strb[6]) set_digits <= set_word;
                end
                EXEC: resp_idx <= '0;
                RESP: begin
                    if (tx_ready) begin
                        if (tx_last) begin
                            len <= '0;
                            ovf <= 1'b0;
                        end else begin
                            resp_idx <= resp_idx + 3'd1;
                        end
                    end
                end
                default: ;
            endcase
            if (rx_vld && (state == DECODE || state == EXEC || state == RESP) && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
            // Pulses arriving while a request is already pending collapse into it.
            err_pend <= (err_pend | err_req) & ~err_svc;
        end
    end

    assign {set_vld, cmd_shutdown, cmd_exit, cmd_setcl, cmd_check, cmd_reset, cmd_start} = strb;
    assign tx_valid = (state == RESP);
    assign tx_data  = tx_valid ? resp_byte(resp_err, resp_idx) : 8'h00;
    assign busy     = (state != COLLECT);

endmodule

// File: tb/tb_uart_cmd_line.sv
// Self-checking bench for uart_cmd_line: table of directed lines, directed
// multi-cycle corner cases, and randomized lines checked against a string
// level reference model.
module tb_uart_cmd_line;
    localparam int MAX_LEN = 16;
    localparam logic [63:0] R_OK  = 64'h4F4B0A;
    localparam logic [63:0] R_ERR = 64'h4552524F52210A;

    logic        clk, rst_n, rx_vld, err_req, tx_valid, tx_ready;
    logic [7:0]  rx_data, tx_data, drop_cnt;
    logic        cmd_start, cmd_reset, cmd_check, cmd_setcl, cmd_exit, cmd_shutdown;
    logic        set_vld, busy;
    logic [23:0] set_digits;
    logic [6:0]  strobes;

    uart_cmd_line #(.MAX_LEN(MAX_LEN), .N_FIELDS(3), .HOUR_MAX(23)) dut (
        .clk(clk), .rst_n(rst_n), .rx_vld(rx_vld), .rx_data(rx_data), .err_req(err_req),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .cmd_start(cmd_start), .cmd_reset(cmd_reset), .cmd_check(cmd_check),
        .cmd_setcl(cmd_setcl), .cmd_exit(cmd_exit), .cmd_shutdown(cmd_shutdown),
        .set_vld(set_vld), .set_digits(set_digits), .busy(busy), .drop_cnt(drop_cnt)
    );

    assign strobes = {set_vld, cmd_shutdown, cmd_exit, cmd_setcl, cmd_check, cmd_reset, cmd_start};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0, n_fail = 0;

    typedef struct {
        string       line;
        logic [6:0]  strb;    // expected strobe, 0 = invalid line
        logic [23:0] digits;  // expected set_digits afterwards
    } vec_t;
    vec_t tbl[$];

    string kws[6] = '{"start", "reset", "check", "setcl", "exit", "shutdown"};

    // Results of the last drain
    logic [63:0] got;
    logic [6:0]  ev_code;
    logic [23:0] ev_dig;
    logic [7:0]  probe_val;
    int got_n, ev_n, ev_k, first_k, last_hs, done_k, probe_k;
    logic busy_k1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs cycles after a trigger cycle T until busy has risen and fallen.
    // Cycle index k counts from T; inputs for cycle T+k are set after sampling.
    task automatic drain(input logic [15:0] inj, input bit rnd, input int hold, input logic [15:0] errm);
        bit seen, pend;
        logic [7:0] pbyte;
        int k;
        got = '0; got_n = 0; ev_n = 0; ev_code = '0; ev_dig = '0; ev_k = -1;
        first_k = -1; last_hs = -1; done_k = -1; busy_k1 = 1'b0;
        seen = 0; pend = 0; pbyte = '0; k = 0;
        while (k < 300) begin
            step();
            k++;
            if (k == 1) busy_k1 = busy;
            if (k == probe_k) probe_val = tx_data;
            if (strobes != '0) begin
                ev_n++; ev_code |= strobes; ev_k = k; ev_dig = set_digits;
            end
            if (tx_valid && first_k < 0) first_k = k;
            if (tx_valid && pend) chk("tx_hold", tx_data, pbyte);
            if (seen && !busy) begin
                done_k = k;
                break;
            end
            if (busy) seen = 1;
            rx_vld   = (k < 16) ? inj[k] : 1'b0;
            rx_data  = 8'($urandom_range(0, 255));
            err_req  = (k < 16) ? errm[k] : 1'b0;
            tx_ready = (k < hold) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            if (tx_valid && tx_ready) begin
                got = {got[55:0], tx_data}; got_n++; last_hs = k; pend = 0;
            end else if (tx_valid) begin
                pend = 1; pbyte = tx_data;
            end
        end
        rx_vld = 1'b0; err_req = 1'b0; tx_ready = 1'b1;
        if (done_k < 0) begin
            n_cmp++; n_fail++;
            $display("FAIL drain_timeout: busy never returned low within 300 cycles");
        end
    endtask

    task automatic send_line(input string s, input bit rnd);
        for (int i = 0; i < s.len(); i++) begin
            rx_vld = 1'b1; rx_data = s[i];
            step();
            rx_vld = 1'b0;
            if (rnd && $urandom_range(0, 3) == 0) step();
        end
    endtask

    task automatic run_line(input string s, input logic [15:0] inj, input bit rnd, input int hold, input bit err_nl);
        send_line(s, rnd);
        rx_vld = 1'b1; rx_data = 8'h0A; err_req = err_nl;
        drain(inj, rnd, hold, 16'h0);
    endtask

    // Checks the outcome of a '\n'-triggered drain.
    task automatic check_resp(input string tag, input logic [6:0] xs, input logic [23:0] xd);
        bit ok;
        ok = (xs != '0);
        chk({tag, ".tx"}, got, ok ? R_OK : R_ERR);
        chk({tag, ".tx_n"}, 64'(got_n), ok ? 64'd3 : 64'd7);
        chk({tag, ".strobe"}, 64'(ev_code), 64'(xs));
        chk({tag, ".strobe_cycles"}, 64'(ev_n), ok ? 64'd1 : 64'd0);
        if (ok) chk({tag, ".strobe_at"}, 64'(ev_k), 64'd2);
        if (xs[6]) chk({tag, ".set_word"}, 64'(ev_dig), 64'(xd));
        chk({tag, ".set_digits"}, 64'(set_digits), 64'(xd));
        chk({tag, ".busy_rise"}, 64'(busy_k1), 64'd1);
        chk({tag, ".first_tx"}, 64'(first_k), 64'd3);
        chk({tag, ".busy_fall"}, 64'(done_k), 64'(last_hs + 1));
    endtask

    task automatic quiet(input string name, input int n);
        bit bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (tx_valid || busy || strobes != '0) bad = 1;
        end
        chk(name, 64'(bad), 64'd0);
    endtask

    // Reference: strip CRs, then apply the line rules directly on the string.
    function automatic void ref_model(input string s, input logic [23:0] cur,
                                      output logic [6:0] xs, output logic [23:0] xd);
        string t;
        bit ok;
        int v;
        t = "";
        for (int i = 0; i < s.len(); i++)
            if (s[i] != 8'h0D) t = $sformatf("%s%c", t, s[i]);
        xs = '0;
        xd = cur;
        if (t.len() == 0 || t.len() > MAX_LEN) return;
        for (int k = 0; k < 6; k++)
            if (t == kws[k]) xs = 7'(1 << k);
        if (t.len() == 8 && t[0] == 8'h73 && t[1] == 8'h20) begin
            ok = 1;
            for (int i = 2; i < 8; i++)
                if (t[i] < 8'h30 || t[i] > 8'h39) ok = 0;
            for (int f = 0; f < 3 && ok; f++) begin
                v = (int'(t[2+2*f]) - 48) * 10 + (int'(t[3+2*f]) - 48);
                if (v > (f == 0 ? 23 : 59)) ok = 0;
            end
            if (ok) begin
                xs = 7'h40;
                xd = '0;
                for (int i = 2; i < 8; i++) xd = {xd[19:0], 4'(int'(t[i]) - 48)};
            end
        end
    endfunction

    function automatic string rand_line();
        string s;
        int c, n;
        s = "";
        c = $urandom_range(0, 5);
        case (c)
            0: s = kws[$urandom_range(0, 5)];
            1: s = $sformatf("%s%c", kws[$urandom_range(0, 5)], 8'($urandom_range(97, 122)));
            2: s = $sformatf("s %02d%02d%02d", $urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
            3: begin
                s = "s ";
                for (int i = 0; i < 6; i++) s = $sformatf("%s%c", s, 8'($urandom_range(48, 57)));
            end
            4: begin
                n = $urandom_range(0, MAX_LEN);
                for (int i = 0; i < n; i++) s = $sformatf("%s%c", s, 8'($urandom_range(32, 126)));
            end
            default: begin
                s = kws[$urandom_range(0, 5)];
                n = $urandom_range(0, s.len());
                s = $sformatf("%s%c%s%c", s.substr(0, n - 1), 8'h0D, s.substr(n, s.len() - 1), 8'h0D);
            end
        endcase
        return s;
    endfunction

    task automatic add(input string l, input logic [6:0] s, input logic [23:0] d);
        vec_t v;
        v.line = l; v.strb = s; v.digits = d;
        tbl.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0]  xs;
        logic [23:0] xd, mdl_dig;
        int mdl_drops;
        logic [15:0] inj;
        string s;

        rst_n = 1'b0; rx_vld = 1'b0; rx_data = '0; err_req = 1'b0; tx_ready = 1'b1;
        probe_k = 0; probe_val = '0;
        step(); step(); step();
        chk("reset_outputs", {tx_valid, busy, strobes, drop_cnt, tx_data, set_digits}, '0);
        rst_n = 1'b1;
        step();
        chk("post_reset_outputs", {tx_valid, busy, strobes, drop_cnt, tx_data, set_digits}, '0);

        // Back-pressure: response held 10 cycles, 3 bytes injected meanwhile.
        probe_k = 12;
        run_line("check", 16'b0000_0001_0101_0000, 0, 13, 0);
        probe_k = 0;
        chk("stall.tx_data_held", 64'(probe_val), 64'h4F);
        check_resp("stall", 7'h04, 24'h0);
        chk("stall.drop_cnt", 64'(drop_cnt), 64'd3);

        add("start", 7'h01, 24'h000000);
        add("reset", 7'h02, 24'h000000);
        add("check", 7'h04, 24'h000000);
        add("setcl", 7'h08, 24'h000000);
        add("exit", 7'h10, 24'h000000);
        add("shutdown", 7'h20, 24'h000000);
        add("s 123456", 7'h40, 24'h123456);
        add("s 235959", 7'h40, 24'h235959);
        add("s 240000", 7'h00, 24'h235959);
        add("s 236059", 7'h00, 24'h235959);
        add("s 235960", 7'h00, 24'h235959);
        add("startx", 7'h00, 24'h235959);
        add("", 7'h00, 24'h235959);
        add("s 23595", 7'h00, 24'h235959);
        add("st\015art\015", 7'h01, 24'h235959);
        add("s 2a5959", 7'h00, 24'h235959);
        add("Start", 7'h00, 24'h235959);
        add("exi", 7'h00, 24'h235959);
        add("s 000000", 7'h40, 24'h000000);
        for (int i = 0; i < tbl.size(); i++) begin
            run_line(tbl[i].line, 16'h0, 0, 0, 0);
            check_resp($sformatf("vec%0d", i), tbl[i].strb, tbl[i].digits);
        end

        // Randomized lines, random tx_ready, random drops during processing.
        mdl_dig = 24'h0;
        mdl_drops = 3;
        for (int it = 0; it < 60; it++) begin
            s = rand_line();
            ref_model(s, mdl_dig, xs, xd);
            inj = 16'($urandom_range(0, 7)) << 1;
            mdl_drops += $countones(inj);
            run_line(s, inj, 1, 0, 0);
            check_resp($sformatf("rnd%0d", it), xs, xd);
            chk($sformatf("rnd%0d.drop_cnt", it), 64'(drop_cnt), 64'(mdl_drops));
            mdl_dig = xd;
        end

        // Overflow: 20 bytes into a 16-byte buffer gives a single error.
        s = "";
        for (int i = 0; i < 20; i++) s = {s, "a"};
        run_line(s, 16'h0, 0, 0, 0);
        check_resp("ovf", 7'h00, mdl_dig);
        quiet("ovf.single_resp", 8);
        run_line("exit", 16'h0, 0, 0, 0);
        check_resp("ovf_exit", 7'h10, mdl_dig);

        // err_req while idle.
        err_req = 1'b1;
        drain(16'h0, 0, 0, 16'h0);
        chk("err_idle.tx", got, R_ERR);
        chk("err_idle.strobe", 64'(ev_code), 64'h0);
        chk("err_idle.first_tx", 64'(first_k), 64'd3);
        quiet("err_idle.single_resp", 8);

        // err_req together with the '\n' of "reset": line first, error after.
        run_line("reset", 16'h0, 0, 0, 1);
        check_resp("err_nl", 7'h02, mdl_dig);
        drain(16'h0, 0, 0, 16'h0);
        chk("err_nl.second_tx", got, R_ERR);
        chk("err_nl.second_strobe", 64'(ev_code), 64'h0);
        quiet("err_nl.quiet", 8);

        // Two err_req pulses while busy merge into one error response.
        send_line("start", 0);
        rx_vld = 1'b1; rx_data = 8'h0A;
        drain(16'h0, 0, 0, 16'b0000_0000_0000_1010);
        chk("err_merge.first", got, R_OK);
        drain(16'h0, 0, 0, 16'h0);
        chk("err_merge.second", got, R_ERR);
        quiet("err_merge.single", 8);

        // Reset in the middle of a stalled response.
        tx_ready = 1'b0;
        send_line("exit", 0);
        rx_vld = 1'b1; rx_data = 8'h0A;
        step();
        rx_vld = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("midrst.pre", {tx_valid, tx_data}, {1'b1, 8'h4F});
        rst_n = 1'b0;
        #1;
        chk("midrst.outputs", {tx_valid, busy, strobes, drop_cnt, tx_data, set_digits}, '0);
        step(); step();
        rst_n = 1'b1;
        tx_ready = 1'b1;
        quiet("midrst.no_resend", 6);
        run_line("exit", 16'h0, 0, 0, 0);
        check_resp("midrst_exit", 7'h10, 24'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
